flash_line_cache: RTL and testbench
===================================

// Module: flash_line_cache
// PURPOSE
//  Single-line read cache / line-fill sequencer between the core's cartridge-ROM read port and
//  the flash read-only controller. CPU word reads use a toggle req/ack handshake; hits return in
//  1 cycle, misses fill one aligned line of 2**LINE_LOG2 words from flash, one word per flash
//  transaction, acking the CPU as soon as its word arrives. Hides ~20-cycle flash latency on
//  sequential code fetch.
// PARAMETERS
//  LINE_LOG2   2    log2 of words per line (line = 4 words = 8 flash bytes)
//  CPU_AW      22   CPU word-address width (flash byte address = {word_addr,1'b0}, 23 bits)
// PORTS
//  iclk        in   1        system clock (54 MHz)
//  ireset      in   1        synchronous, active-high reset
//  icpu_addr   in   CPU_AW   CPU word address, stable while icpu_req != ocpu_ack
//  icpu_req    in   1        toggle: new read when icpu_req != ocpu_ack
//  ocpu_ack    out  1        toggle: set equal to icpu_req when ocpu_dout valid
//  ocpu_dout   out  16       read data word
//  iflush      in   1        1-cycle pulse: invalidate line (ROM reload / mapper change)
//  ofl_addr    out  23       flash byte address (always even)
//  ofl_req     out  1        toggle request to flash controller
//  ifl_ack     in   1        flash ack toggle; transaction done when ifl_ack == ofl_req
//  ifl_dout    in   16       flash word, passed through unmodified (byte order as delivered)
// BEHAVIOUR
//  Reset (ireset=1, every cycle): state<=IDLE; valid[]<=0; tag<=0; flush_pend<=0;
//   ocpu_ack<=icpu_req; ocpu_dout<=0; ofl_addr<=0; ofl_req HOLDS its value (flash controller
//   copies req into ack during its own reset). After reset no flash request is issued until
//   ifl_ack == ofl_req.
//  Line: tag = addr[CPU_AW-1:LINE_LOG2]; idx = addr[LINE_LOG2-1:0]; storage 2**LINE_LOG2 x 16,
//   per-word valid bits.
//  IDLE: pending CPU req (icpu_req != ocpu_ack) and flash idle:
//   - hit (tag match & valid[idx]): next edge ocpu_dout<=word[idx], ocpu_ack<=icpu_req (1-cycle).
//   - miss: valid[]<=0, tag<=new tag, fill_idx<=0, ofl_addr<={tag,0..0,1'b0}, toggle ofl_req,
//     -> FILL.
//  FILL: on edge where ifl_ack == ofl_req: word[fill_idx]<=ifl_dout, valid[fill_idx]<=1;
//   if CPU req pending, tag match and idx==fill_idx: ocpu_dout<=ifl_dout, ocpu_ack<=icpu_req
//   on that same edge. If fill_idx != last: fill_idx+1, ofl_addr+2, toggle ofl_req on the same
//   edge (back-to-back). If last: -> IDLE.
//  FILL, CPU req with tag match & word already valid: served next edge as hit, fill continues.
//   Tag match & word not yet valid: waits for its word. Tag mismatch: held until line
//   complete, then handled from IDLE as a miss. Never abort an in-flight flash transaction.
//  iflush: in IDLE clears valid[] next edge. In FILL sets flush_pend; on fill completion
//   valid[] cleared, flush_pend<=0 (word delivered during fill is still acked). Flush and miss
//   in same IDLE cycle: miss wins (valid cleared anyway).
//  At most one CPU and one flash transaction outstanding (toggle protocol). Tag compare is
//   full-width; line address wraps nowhere (line aligned, fill_idx wraps only at line end).
//  Reset mid-FILL: state forced per reset list; partial line discarded.
// STRUCTURE
//  flash_pkg: FLASH_AW=23, CPU_AW default, state enum {IDLE, FILL}, flash byte-addr helper.
//  Sub-module flash_line_ram: 2**LINE_LOG2 x 16 register file, 1 write / 1 async read port.
//  FSM, tag/valid, handshake logic in flash_line_cache.
// TESTING (flash_line_cache + behavioural flash model with 20-cycle latency)
//  1 Reset: hold ireset 5 cycles with icpu_req=1 -> ocpu_ack=1, ofl_req unchanged, no flash
//    activity, valid all 0.
//  2 Cold miss: read addr 0x000005 -> flash addrs 0x00008,0x0000A,0x0000C,0x0000E in order;
//    ocpu_ack toggles on 2nd flash completion with data = model word at byte 0x0000A.
//  3 Hits: then reads 0x000004, 0x000007 -> each acked exactly 1 cycle after req, no flash req.
//  4 Mid-fill: miss at 0x000010 then, after 1st word, req 0x000010 again (valid) -> 1-cycle
//    hit; req 0x000020 during fill -> waits, new fill at 0x00040 starts after 0x00026 done.
//  5 Flush: iflush during fill of line 0x000030 -> line completes, re-read 0x000030 misses
//    (new flash req 0x00060).
//  6 Reset mid-fill: assert ireset after 2nd word -> no further flash reqs, next read of same
//    line refills all 4 words.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared widths, FSM states and address helper for the flash line cache.
package flash_pkg;

  localparam int unsigned FLASH_AW      = 23;
  localparam int unsigned CPU_AW_DEF    = 22;
  localparam int unsigned LINE_LOG2_DEF = 2;
  localparam int unsigned DATA_W        = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Flash byte address of a flash word address (words are 2 bytes, always even).
  function automatic logic [FLASH_AW-1:0] fl_byte_addr(input logic [FLASH_AW-2:0] word_addr);
    return {word_addr, 1'b0};
  endfunction

endpackage

// File: rtl/flash_line_ram.sv
// Line storage: 2**DEPTH_LOG2 x DATA_W register file, one write port, one async read port.
module flash_line_ram #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                  iclk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word write; contents need no reset because valid bits gate every use.
  always_ff @(posedge iclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/flash_line_cache.sv
// Single-line read cache and line-fill sequencer between the CPU ROM port and flash.
module flash_line_cache
  import flash_pkg::*;
#(
  parameter int unsigned LINE_LOG2 = LINE_LOG2_DEF,
  parameter int unsigned CPU_AW    = CPU_AW_DEF
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic [CPU_AW-1:0]   icpu_addr,
  input  logic                icpu_req,
  output logic                ocpu_ack,
  output logic [DATA_W-1:0]   ocpu_dout,
  input  logic                iflush,
  output logic [FLASH_AW-1:0] ofl_addr,
  output logic                ofl_req,
  input  logic                ifl_ack,
  input  logic [DATA_W-1:0]   ifl_dout
);

  localparam int unsigned WORDS = 1 << LINE_LOG2;
  localparam int unsigned TAG_W = CPU_AW - LINE_LOG2;
  localparam int unsigned FLW_W = FLASH_AW - 1;
  localparam logic [LINE_LOG2-1:0] LAST_IDX = LINE_LOG2'(WORDS - 1);

  state_t                state, state_n;
  logic [WORDS-1:0]      valid, valid_n;
  logic [TAG_W-1:0]      tag, tag_n;
  logic                  flush_pend, flush_pend_n;
  logic [LINE_LOG2-1:0]  fill_idx, fill_idx_n;
  logic                  ack_n;
  logic [DATA_W-1:0]     dout_n;
  logic [FLASH_AW-1:0]   fl_addr_n;
  logic                  fl_req_n;

  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata_c;

  logic [TAG_W-1:0]      req_tag;
  logic [LINE_LOG2-1:0]  req_idx;
  logic                  cpu_pend;
  logic                  fl_idle;
  logic                  tag_match;
  logic                  line_hit;

  assign req_tag   = icpu_addr[CPU_AW-1:LINE_LOG2];
  assign req_idx   = icpu_addr[LINE_LOG2-1:0];
  assign cpu_pend  = (icpu_req != ocpu_ack);
  assign fl_idle   = (ifl_ack == ofl_req);
  assign tag_match = (req_tag == tag);
  assign line_hit  = tag_match && valid[req_idx];

  flash_line_ram #(
    .DEPTH_LOG2 (LINE_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .iclk    (iclk),
    .we      (ram_we),
    .waddr   (fill_idx),
    .wdata   (ifl_dout),
    .raddr   (req_idx),
    .rdata_c (ram_rdata_c)
  );

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, line bookkeeping and handshake decisions.
  always_comb begin
    state_n      = state;
    valid_n      = valid;
    tag_n        = tag;
    flush_pend_n = flush_pend;
    fill_idx_n   = fill_idx;
    ack_n        = ocpu_ack;
    dout_n       = ocpu_dout;
    fl_addr_n    = ofl_addr;
    fl_req_n     = ofl_req;
    ram_we       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (iflush) begin
          valid_n = '0;
        end
        if (cpu_pend && fl_idle) begin
          if (line_hit) begin
            dout_n = ram_rdata_c;
            ack_n  = icpu_req;
          end else begin
            valid_n      = '0;
            tag_n        = req_tag;
            fill_idx_n   = '0;
            flush_pend_n = 1'b0;
            fl_addr_n    = fl_byte_addr(FLW_W'({req_tag, {LINE_LOG2{1'b0}}}));
            fl_req_n     = ~ofl_req;
            state_n      = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (iflush) begin
          flush_pend_n = 1'b1;
        end
        // Words already in the line are served while the fill continues.
        if (cpu_pend && line_hit) begin
          dout_n = ram_rdata_c;
          ack_n  = icpu_req;
        end
        if (fl_idle) begin
          ram_we            = 1'b1;
          valid_n[fill_idx] = 1'b1;
          if (cpu_pend && tag_match && (req_idx == fill_idx)) begin
            dout_n = ifl_dout;
            ack_n  = icpu_req;
          end
          if (fill_idx != LAST_IDX) begin
            fill_idx_n = fill_idx + LINE_LOG2'(1);
            fl_addr_n  = ofl_addr + FLASH_AW'(2);
            fl_req_n   = ~ofl_req;
          end else begin
            state_n      = ST_IDLE;
            flush_pend_n = 1'b0;
            if (flush_pend || iflush) begin
              valid_n = '0;
            end
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath and output registers; the flash request toggle survives reset.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      valid      <= '0;
      tag        <= '0;
      flush_pend <= 1'b0;
      fill_idx   <= '0;
      ocpu_ack   <= icpu_req;
      ocpu_dout  <= '0;
      ofl_addr   <= '0;
    end else begin
      valid      <= valid_n;
      tag        <= tag_n;
      flush_pend <= flush_pend_n;
      fill_idx   <= fill_idx_n;
      ocpu_ack   <= ack_n;
      ocpu_dout  <= dout_n;
      ofl_addr   <= fl_addr_n;
      ofl_req    <= fl_req_n;
    end
  end

endmodule

// File: tb/tb_flash_line_cache.sv
// Self-checking bench for flash_line_cache with a behavioural toggle-handshake flash model.
module tb_flash_line_cache;

  logic        iclk;
  logic        ireset;
  logic [21:0] icpu_addr;
  logic        icpu_req;
  logic        ocpu_ack;
  logic [15:0] ocpu_dout;
  logic        iflush;
  logic [22:0] ofl_addr;
  logic        ofl_req;
  logic        ifl_ack;
  logic [15:0] ifl_dout;

  int checks = 0;
  int errors = 0;

  int          fl_lat  = 20;
  int          fl_cnt  = 0;
  int          fl_done = 0;
  logic [22:0] fl_cur;
  logic [22:0] fl_log[$];

  flash_line_cache dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .icpu_addr (icpu_addr),
    .icpu_req  (icpu_req),
    .ocpu_ack  (ocpu_ack),
    .ocpu_dout (ocpu_dout),
    .iflush    (iflush),
    .ofl_addr  (ofl_addr),
    .ofl_req   (ofl_req),
    .ifl_ack   (ifl_ack),
    .ifl_dout  (ifl_dout)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Flash contents as a function of byte address.
  function automatic logic [15:0] fl_word(input logic [22:0] a);
    return a[15:0] ^ {a[22:16], 9'h000} ^ 16'hC35A;
  endfunction

  // Returns -1 when the flash request log equals e, else -2 (size) or first bad index.
  function automatic int log_diff(input logic [22:0] e[$]);
    if (e.size() != fl_log.size()) return -2;
    foreach (e[i]) if (e[i] !== fl_log[i]) return i;
    return -1;
  endfunction

  // Flash controller model: one transaction at a time, fixed latency, ack copies req in reset.
  initial begin
    ifl_ack  = 1'b0;
    ifl_dout = 16'h0000;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        ifl_ack = ofl_req;
        fl_cnt  = 0;
      end else if (fl_cnt != 0) begin
        fl_cnt--;
        if (fl_cnt == 0) begin
          ifl_dout = fl_word(fl_cur);
          ifl_ack  = ofl_req;
          fl_done++;
        end
      end else if (ofl_req != ifl_ack) begin
        fl_cur = ofl_addr;
        fl_log.push_back(ofl_addr);
        fl_cnt = fl_lat;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_read(input logic [21:0] a, output logic [15:0] d, output int cyc);
    bit to;
    icpu_addr = a;
    icpu_req  = ~icpu_req;
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge iclk);
      cyc++;
      if (ocpu_ack == icpu_req) begin
        to = 1'b0;
        break;
      end
    end
    d = ocpu_dout;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL cpu_ack_timeout addr=%h: ack=%b req=%b after %0d cycles", a, ocpu_ack, icpu_req, cyc);
    end
  endtask

  task automatic wait_flash_idle();
    int stable = 0;
    for (int i = 0; i < 600 && stable < 3; i++) begin
      @(negedge iclk);
      if (fl_cnt == 0 && ofl_req == ifl_ack) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 3) begin
      errors++;
      $display("FAIL flash_idle_timeout: req=%b ack=%b cnt=%0d", ofl_req, ifl_ack, fl_cnt);
    end
  endtask

  task automatic pulse_flush();
    iflush = 1'b1;
    @(negedge iclk);
    iflush = 1'b0;
  endtask

  task automatic test_reset();
    logic req0;
    ireset   = 1'b1;
    icpu_req = 1'b1;
    @(negedge iclk);
    req0 = ofl_req;
    repeat (4) @(negedge iclk);
    checks++; if (ocpu_ack !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b want 1", ocpu_ack); end
    checks++; if (ofl_req !== req0) begin errors++; $display("FAIL reset_fl_req_hold: got %b want %b", ofl_req, req0); end
    checks++; if (ocpu_dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h want 0000", ocpu_dout); end
    checks++; if (ofl_addr !== 23'h0) begin errors++; $display("FAIL reset_fl_addr: got %h want 000000", ofl_addr); end
    checks++; if (dut.valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", dut.valid); end
    ireset = 1'b0;
    repeat (5) @(negedge iclk);
    checks++; if (fl_log.size() != 0) begin errors++; $display("FAIL reset_no_flash: got %0d reqs want 0", fl_log.size()); end
    checks++; if (ocpu_ack !== 1'b1) begin errors++; $display("FAIL reset_no_spurious_ack: got %b want 1", ocpu_ack); end
  endtask

  task automatic test_cold_miss();
    logic [15:0] d;
    int cyc;
    int done0;
    logic [22:0] e[$];
    fl_log.delete();
    done0 = fl_done;
    cpu_read(22'h000005, d, cyc);
    checks++; if (d !== fl_word(23'h0000A)) begin errors++; $display("FAIL cold_data: got %h want %h", d, fl_word(23'h0000A)); end
    checks++; if (fl_done - done0 != 2) begin errors++; $display("FAIL cold_ack_on_2nd: got %0d completions want 2", fl_done - done0); end
    wait_flash_idle();
    e = '{23'h00008, 23'h0000A, 23'h0000C, 23'h0000E};
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL cold_flash_seq: diff=%0d size=%0d want 4 in order", log_diff(e), fl_log.size()); end
  endtask

  task automatic test_hits();
    logic [15:0] d;
    int cyc;
    fl_log.delete();
    cpu_read(22'h000004, d, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL hit4_latency: got %0d want 1", cyc); end
    checks++; if (d !== fl_word(23'h00008)) begin errors++; $display("FAIL hit4_data: got %h want %h", d, fl_word(23'h00008)); end
    cpu_read(22'h000007, d, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL hit7_latency: got %0d want 1", cyc); end
    checks++; if (d !== fl_word(23'h0000E)) begin errors++; $display("FAIL hit7_data: got %h want %h", d, fl_word(23'h0000E)); end
    repeat (3) @(negedge iclk);
    checks++; if (fl_log.size() != 0) begin errors++; $display("FAIL hit_no_flash: got %0d reqs want 0", fl_log.size()); end
  endtask

  task automatic test_mid_fill();
    logic [15:0] d;
    int cyc;
    int done0;
    logic [22:0] e[$];
    fl_log.delete();
    done0 = fl_done;
    cpu_read(22'h000010, d, cyc);
    checks++; if (d !== fl_word(23'h00020)) begin errors++; $display("FAIL mid_first_data: got %h want %h", d, fl_word(23'h00020)); end
    cpu_read(22'h000010, d, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL mid_hit_latency: got %0d want 1", cyc); end
    checks++; if (d !== fl_word(23'h00020)) begin errors++; $display("FAIL mid_hit_data: got %h want %h", d, fl_word(23'h00020)); end
    cpu_read(22'h000020, d, cyc);
    checks++; if (d !== fl_word(23'h00040)) begin errors++; $display("FAIL mid_other_data: got %h want %h", d, fl_word(23'h00040)); end
    checks++; if (fl_done - done0 != 5) begin errors++; $display("FAIL mid_other_wait: got %0d completions want 5", fl_done - done0); end
    wait_flash_idle();
    e = '{23'h00020, 23'h00022, 23'h00024, 23'h00026, 23'h00040, 23'h00042, 23'h00044, 23'h00046};
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL mid_flash_seq: diff=%0d size=%0d want 8", log_diff(e), fl_log.size()); end
  endtask

  task automatic test_flush();
    logic [15:0] d;
    int cyc;
    logic [22:0] e[$];
    e = '{23'h00060, 23'h00062, 23'h00064, 23'h00066};
    fl_log.delete();
    cpu_read(22'h000030, d, cyc);
    pulse_flush();
    wait_flash_idle();
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL flush_fill_completes: diff=%0d size=%0d want 4", log_diff(e), fl_log.size()); end
    fl_log.delete();
    cpu_read(22'h000030, d, cyc);
    checks++; if (d !== fl_word(23'h00060)) begin errors++; $display("FAIL flush_reread_data: got %h want %h", d, fl_word(23'h00060)); end
    wait_flash_idle();
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL flush_reread_miss: diff=%0d size=%0d want 4", log_diff(e), fl_log.size()); end
    pulse_flush();
    fl_log.delete();
    cpu_read(22'h000031, d, cyc);
    checks++; if (d !== fl_word(23'h00062)) begin errors++; $display("FAIL idle_flush_data: got %h want %h", d, fl_word(23'h00062)); end
    wait_flash_idle();
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL idle_flush_miss: diff=%0d size=%0d want 4", log_diff(e), fl_log.size()); end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] d;
    int cyc;
    int done0;
    int n0;
    bit seen;
    logic [22:0] e[$];
    fl_log.delete();
    done0 = fl_done;
    cpu_read(22'h000050, d, cyc);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fl_done - done0 >= 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge iclk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_second_word: got %0d completions want 2", fl_done - done0); end
    ireset = 1'b1;
    repeat (3) @(negedge iclk);
    n0 = fl_log.size();
    ireset = 1'b0;
    repeat (60) @(negedge iclk);
    checks++; if (fl_log.size() != n0) begin errors++; $display("FAIL rst_mid_no_more_reqs: got %0d reqs want %0d", fl_log.size(), n0); end
    checks++; if (ocpu_ack !== icpu_req) begin errors++; $display("FAIL rst_mid_cpu_idle: ack=%b want %b", ocpu_ack, icpu_req); end
    fl_log.delete();
    cpu_read(22'h000051, d, cyc);
    checks++; if (d !== fl_word(23'h000A2)) begin errors++; $display("FAIL rst_mid_refill_data: got %h want %h", d, fl_word(23'h000A2)); end
    wait_flash_idle();
    e = '{23'h000A0, 23'h000A2, 23'h000A4, 23'h000A6};
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL rst_mid_refill_seq: diff=%0d size=%0d want 4", log_diff(e), fl_log.size()); end
  endtask

  // Random reads over four lines with random flash latency; model tracks which line is resident.
  task automatic test_random();
    logic [15:0] d;
    logic [21:0] a;
    int cyc;
    bit res_v;
    logic [19:0] res_tag;
    logic [22:0] e[$];
    wait_flash_idle();
    pulse_flush();
    res_v   = 1'b0;
    res_tag = '0;
    fl_log.delete();
    for (int n = 0; n < 40; n++) begin
      a      = 22'h000100 + 22'($urandom_range(0, 15));
      fl_lat = $urandom_range(1, 24);
      if (!res_v || a[21:2] != res_tag) begin
        res_v   = 1'b1;
        res_tag = a[21:2];
        for (int k = 0; k < 4; k++) e.push_back({res_tag, 2'(k), 1'b0});
      end
      cpu_read(a, d, cyc);
      checks++; if (d !== fl_word({a, 1'b0})) begin errors++; $display("FAIL rand_data[%0d] addr=%h: got %h want %h", n, a, d, fl_word({a, 1'b0})); end
      repeat ($urandom_range(0, 3)) @(negedge iclk);
    end
    wait_flash_idle();
    checks++; if (log_diff(e) != -1) begin errors++; $display("FAIL rand_flash_seq: diff=%0d size=%0d want %0d", log_diff(e), fl_log.size(), e.size()); end
    fl_lat = 20;
  endtask

  initial begin
    ireset    = 1'b1;
    icpu_req  = 1'b0;
    icpu_addr = '0;
    iflush    = 1'b0;
    test_reset();
    test_cold_miss();
    test_hits();
    test_mid_fill();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
